// File: rtl/dice_pkg.sv
// rtl/dice_pkg.sv - shared states, craps constants and LFSR helpers for dice_stim_gen
package dice_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_ROLL,
        ST_PRESENT,
        ST_CHECK,
        ST_DONE
    } dice_state_e;

    localparam int WIN_A  = 7;
    localparam int WIN_B  = 11;
    localparam int LOSE_A = 2;
    localparam int LOSE_B = 3;
    localparam int LOSE_C = 12;

    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/dice_stim_gen_if.sv
// rtl/dice_stim_gen_if.sv - roll/outcome handshake between stimulus generator and dice controller
interface dice_stim_gen_if #(
    parameter int SUM_W = 4
);
    logic             rb_o;
    logic             reset_o;
    logic [SUM_W-1:0] sum_o;
    logic             roll_i;
    logic             win_i;
    logic             lose_i;

    modport master (
        output rb_o, reset_o, sum_o,
        input  roll_i, win_i, lose_i
    );

    modport slave (
        input  rb_o, reset_o, sum_o,
        output roll_i, win_i, lose_i
    );
endinterface

// File: rtl/dice_lfsr.sv
// rtl/dice_lfsr.sv - seedable 16-bit LFSR producing a two-die sum
module dice_lfsr
    import dice_pkg::*;
#(
    parameter int SUM_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [15:0]      seed,
    input  logic             advance,
    output logic [SUM_W-1:0] sum
);
    logic [15:0] lfsr;
    logic [2:0]  d1;
    logic [2:0]  d2;

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= DEFAULT_SEED;
        end else if (load) begin
            lfsr <= (seed == 16'h0) ? DEFAULT_SEED : seed;
        end else if (advance) begin
            lfsr <= lfsr_next(lfsr);
        end
    end

    // Mod-6 of a 3-bit field favours 1 and 2 slightly; that bias is acceptable here
    assign d1  = (lfsr[2:0] % 3'd6) + 3'd1;
    assign d2  = (lfsr[5:3] % 3'd6) + 3'd1;
    assign sum = SUM_W'({1'b0, d1} + {1'b0, d2});

endmodule

// File: rtl/dice_stim_gen.sv
// rtl/dice_stim_gen.sv - dice-game stimulus generator with built-in outcome scoreboard
module dice_stim_gen
    import dice_pkg::*;
#(
    parameter int MAX_ROLLS = 16,
    parameter int SUM_W     = 4,
    parameter int ERR_W     = 8,
    parameter int CNT_W     = $clog2(MAX_ROLLS + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start_i,
    input  logic                         mode_i,
    input  logic [15:0]                  seed_i,
    input  logic [CNT_W-1:0]             n_rolls_i,
    input  logic                         tbl_we_i,
    input  logic [$clog2(MAX_ROLLS)-1:0] tbl_addr_i,
    input  logic [SUM_W-1:0]             tbl_data_i,
    dice_stim_gen_if.master              dut_if,
    output logic                         busy_o,
    output logic                         done_o,
    output logic [CNT_W-1:0]             roll_cnt_o,
    output logic [ERR_W-1:0]             err_cnt_o
);
    localparam int AW = $clog2(MAX_ROLLS);

    dice_state_e      state, state_nxt;
    logic [SUM_W-1:0] tbl [MAX_ROLLS];
    logic [SUM_W-1:0] sum_r, point, lfsr_sum, next_sum;
    logic [CNT_W-1:0] roll_cnt, n_rolls_r, n_eff;
    logic [ERR_W-1:0] err_cnt;
    logic             mode_r, first_roll;
    logic             start_ok, roll_ok, exp_win, exp_lose, mismatch;
    logic             rb, new_game;

    assign start_ok = start_i && (state == ST_IDLE || state == ST_DONE);
    assign roll_ok  = (state == ST_WAIT_ROLL) && dut_if.roll_i;
    assign n_eff    = (n_rolls_i > CNT_W'(MAX_ROLLS)) ? CNT_W'(MAX_ROLLS) : n_rolls_i;
    assign next_sum = mode_r ? lfsr_sum : tbl[roll_cnt[AW-1:0]];

    dice_lfsr #(.SUM_W(SUM_W)) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .load    (start_ok),
        .seed    (seed_i),
        .advance (roll_ok && mode_r),
        .sum     (lfsr_sum)
    );

    always_ff @(posedge clk) begin
        if (tbl_we_i) begin
            tbl[tbl_addr_i] <= tbl_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rb        = 1'b0;
        new_game  = 1'b0;
        busy_o    = 1'b0;
        done_o    = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                done_o = (state == ST_DONE);
                if (start_ok) begin
                    state_nxt = (n_eff == '0) ? ST_DONE : ST_WAIT_ROLL;
                end
            end
            ST_WAIT_ROLL: begin
                rb     = 1'b1;
                busy_o = 1'b1;
                if (dut_if.roll_i) begin
                    state_nxt = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                busy_o    = 1'b1;
                state_nxt = ST_CHECK;
            end
            ST_CHECK: begin
                busy_o    = 1'b1;
                new_game  = dut_if.win_i || dut_if.lose_i;
                state_nxt = (roll_cnt == n_rolls_r) ? ST_DONE : ST_WAIT_ROLL;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Out-of-range table values fall through every comparison and become points
    always_comb begin
        exp_win  = 1'b0;
        exp_lose = 1'b0;
        if (first_roll) begin
            exp_win  = (sum_r == SUM_W'(WIN_A)) || (sum_r == SUM_W'(WIN_B));
            exp_lose = (sum_r == SUM_W'(LOSE_A)) || (sum_r == SUM_W'(LOSE_B)) ||
                       (sum_r == SUM_W'(LOSE_C));
        end else begin
            exp_win  = (sum_r == point);
            exp_lose = (sum_r == SUM_W'(WIN_A));
        end
    end

    assign mismatch = (dut_if.win_i != exp_win) || (dut_if.lose_i != exp_lose) ||
                      (dut_if.win_i && dut_if.lose_i);

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_r      <= '0;
            point      <= '0;
            roll_cnt   <= '0;
            n_rolls_r  <= '0;
            err_cnt    <= '0;
            mode_r     <= 1'b0;
            first_roll <= 1'b1;
        end else begin
            if (start_ok) begin
                roll_cnt   <= '0;
                err_cnt    <= '0;
                first_roll <= 1'b1;
                n_rolls_r  <= n_eff;
                mode_r     <= mode_i;
            end
            if (roll_ok) begin
                sum_r    <= next_sum;
                roll_cnt <= roll_cnt + 1'b1;
            end
            if (state == ST_CHECK) begin
                if (mismatch && (err_cnt != '1)) begin
                    err_cnt <= err_cnt + 1'b1;
                end
                if (exp_win || exp_lose) begin
                    first_roll <= 1'b1;
                end else if (first_roll) begin
                    point      <= sum_r;
                    first_roll <= 1'b0;
                end
            end
        end
    end

    assign dut_if.rb_o    = rb;
    assign dut_if.reset_o = new_game;
    assign dut_if.sum_o   = sum_r;
    assign roll_cnt_o     = roll_cnt;
    assign err_cnt_o      = err_cnt;

endmodule

// File: tb/tb_dice_stim_gen.sv
// tb/tb_dice_stim_gen.sv - scoreboard bench for dice_stim_gen with a scripted dice-controller responder
module tb_dice_stim_gen;
    localparam int MAX_ROLLS = 16;
    localparam int SUM_W     = 4;
    localparam int CNT_W     = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             start, mode, tbl_we;
    logic [15:0]      seed;
    logic [CNT_W-1:0] n_rolls;
    logic [3:0]       tbl_addr;
    logic [SUM_W-1:0] tbl_data;
    logic             busy, done, busy2, done2;
    logic [CNT_W-1:0] roll_cnt, roll_cnt2;
    logic [7:0]       err_cnt;
    logic [1:0]       err_cnt2;
    logic             roll_d = 1'b0, win_d = 1'b0, lose_d = 1'b0;

    always #5 clk = ~clk;

    dice_stim_gen_if #(.SUM_W(SUM_W)) dif  ();
    dice_stim_gen_if #(.SUM_W(SUM_W)) dif2 ();

    assign dif.roll_i  = roll_d;
    assign dif.win_i   = win_d;
    assign dif.lose_i  = lose_d;
    assign dif2.roll_i = roll_d;
    assign dif2.win_i  = win_d;
    assign dif2.lose_i = lose_d;

    dice_stim_gen #(.MAX_ROLLS(MAX_ROLLS), .SUM_W(SUM_W), .ERR_W(8), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .rst(rst), .start_i(start), .mode_i(mode), .seed_i(seed),
        .n_rolls_i(n_rolls), .tbl_we_i(tbl_we), .tbl_addr_i(tbl_addr), .tbl_data_i(tbl_data),
        .dut_if(dif), .busy_o(busy), .done_o(done), .roll_cnt_o(roll_cnt), .err_cnt_o(err_cnt)
    );

    dice_stim_gen #(.MAX_ROLLS(MAX_ROLLS), .SUM_W(SUM_W), .ERR_W(2), .CNT_W(CNT_W)) u_dut2 (
        .clk(clk), .rst(rst), .start_i(start), .mode_i(mode), .seed_i(seed),
        .n_rolls_i(n_rolls), .tbl_we_i(tbl_we), .tbl_addr_i(tbl_addr), .tbl_data_i(tbl_data),
        .dut_if(dif2), .busy_o(busy2), .done_o(done2), .roll_cnt_o(roll_cnt2), .err_cnt_o(err_cnt2)
    );

    int n_checks = 0;
    int n_errors = 0;
    int exp_sum_q[$];
    bit [1:0] resp_q[$];
    int reset_pulses = 0;
    bit lfsr_run = 1'b0;
    int prev_cnt = 0;
    int mon_e;
    bit [1:0] mon_r;

    int tbl_vals[16] = '{7, 11, 2, 4, 7, 5, 6, 7, 6, 8, 9, 6, 8, 5, 10, 3};
    // {win,lose}: W,W,L,-,L,-,-,L,-,-,-,W
    bit [1:0] tbl_resp[12] = '{2'b10, 2'b10, 2'b01, 2'b00, 2'b01, 2'b00,
                               2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b10};

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor plus responder: pops one expected sum per completed roll and
    // answers with the scripted outcome, held until the next roll.
    always @(negedge clk) begin
        roll_d = dif.rb_o;
        if (!rst) begin
            if (dif.reset_o) reset_pulses++;
            if (int'(roll_cnt) != prev_cnt && roll_cnt != '0) begin
                if (exp_sum_q.size() == 0) begin
                    check("sum_unexpected", int'(dif.sum_o), -1);
                end else begin
                    mon_e = exp_sum_q.pop_front();
                    check("sum", int'(dif.sum_o), mon_e);
                end
                if (lfsr_run) check("sum_range", int'(dif.sum_o >= 2 && dif.sum_o <= 12), 1);
                mon_r  = (resp_q.size() != 0) ? resp_q.pop_front() : 2'b00;
                win_d  = mon_r[1];
                lose_d = mon_r[0];
            end
            prev_cnt = int'(roll_cnt);
        end
    end

    task automatic start_run(input bit m, input logic [15:0] sd, input int n);
        @(negedge clk);
        start   = 1'b1;
        mode    = m;
        seed    = sd;
        n_rolls = CNT_W'(n);
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            if (done) break;
            @(negedge clk);
        end
        if (i == budget) check({name, "_timeout"}, 0, 1);
    endtask

    task automatic push_table(input int n, input bit tie);
        for (int i = 0; i < n; i++) begin
            exp_sum_q.push_back(tbl_vals[i]);
            resp_q.push_back((tie || i >= 12) ? 2'b00 : tbl_resp[i]);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_rb"},      int'(dif.rb_o), 0);
        check({name, "_reset_o"}, int'(dif.reset_o), 0);
        check({name, "_sum"},     int'(dif.sum_o), 0);
        check({name, "_busy"},    int'(busy), 0);
        check({name, "_done"},    int'(done), 0);
        check({name, "_rollcnt"}, int'(roll_cnt), 0);
        check({name, "_errcnt"},  int'(err_cnt), 0);
    endtask

    initial begin
        logic [15:0] s;
        int d1, d2, sm, pt, exp_err;
        bit first;
        int i;

        rst = 1'b1; start = 1'b0; mode = 1'b0; seed = '0; n_rolls = '0;
        tbl_we = 1'b0; tbl_addr = '0; tbl_data = '0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;

        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            tbl_we = 1'b1; tbl_addr = 4'(k); tbl_data = SUM_W'(tbl_vals[k]);
        end
        @(negedge clk);
        tbl_we = 1'b0;

        // table replay, correct responder
        push_table(12, 1'b0);
        reset_pulses = 0;
        start_run(1'b0, 16'h0, 12);
        check("t1_rb_after_start", int'(dif.rb_o), 1);
        wait_done("t1", 200);
        check("t1_reset_pulses", reset_pulses, 6);
        check("t1_err", int'(err_cnt), 0);
        check("t1_err_w2", int'(err_cnt2), 0);
        check("t1_rollcnt", int'(roll_cnt), 12);
        check("t1_done", int'(done), 1);
        check("t1_busy", int'(busy), 0);
        check("t1_q_empty", exp_sum_q.size(), 0);

        // same table, responder never reports an outcome
        push_table(12, 1'b1);
        reset_pulses = 0;
        start_run(1'b0, 16'h0, 12);
        wait_done("t2", 200);
        check("t2_err", int'(err_cnt), 6);
        check("t2_err_saturated", int'(err_cnt2), 3);
        check("t2_reset_pulses", reset_pulses, 0);

        // LFSR mode with seed 0 falls back to ACE1
        s = 16'hACE1; first = 1'b1; pt = 0; exp_err = 0;
        for (int k = 0; k < 16; k++) begin
            d1 = (int'(s[2:0]) % 6) + 1;
            d2 = (int'(s[5:3]) % 6) + 1;
            sm = d1 + d2;
            exp_sum_q.push_back(sm);
            resp_q.push_back(2'b00);
            if (first && (sm == 7 || sm == 11 || sm == 2 || sm == 3 || sm == 12)) exp_err++;
            else if (!first && (sm == pt || sm == 7)) begin exp_err++; first = 1'b1; end
            else if (first) begin pt = sm; first = 1'b0; end
            s = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
        end
        lfsr_run = 1'b1;
        start_run(1'b1, 16'h0000, 16);
        wait_done("t3", 300);
        lfsr_run = 1'b0;
        check("t3_rollcnt", int'(roll_cnt), 16);
        check("t3_err", int'(err_cnt), exp_err);
        check("t3_q_empty", exp_sum_q.size(), 0);

        // zero-length run
        start_run(1'b0, 16'h0, 0);
        check("t4_done", int'(done), 1);
        check("t4_rb", int'(dif.rb_o), 0);
        check("t4_busy", int'(busy), 0);
        @(negedge clk);
        check("t4_rb_later", int'(dif.rb_o), 0);

        // over-long request is clamped to MAX_ROLLS
        push_table(16, 1'b1);
        start_run(1'b0, 16'h0, 20);
        wait_done("t5", 300);
        check("t5_rollcnt", int'(roll_cnt), 16);
        check("t5_err", int'(err_cnt), 6);
        check("t5_q_empty", exp_sum_q.size(), 0);

        // reset during PRESENT of roll 5
        push_table(12, 1'b0);
        start_run(1'b0, 16'h0, 12);
        for (i = 0; i < 100; i++) begin
            if (roll_cnt == 5'd5) break;
            @(negedge clk);
        end
        if (i == 100) check("t6_roll5_timeout", 0, 1);
        rst = 1'b1;
        @(negedge clk);
        check_idle_outputs("t6_midrun_reset");
        rst = 1'b0;
        exp_sum_q.delete();
        resp_q.delete();
        @(negedge clk);
        push_table(12, 1'b0);
        reset_pulses = 0;
        start_run(1'b0, 16'h0, 12);
        wait_done("t6", 200);
        check("t6_err", int'(err_cnt), 0);
        check("t6_rollcnt", int'(roll_cnt), 12);
        check("t6_reset_pulses", reset_pulses, 6);
        check("t6_q_empty", exp_sum_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/dice_stim_gen.md
# dice_stim_gen

Parametrised stimulus generator and self-checking scoreboard for the dice-game controller. It drives roll sums into the device under test (DUT) from either a runtime-loadable table or an LFSR-based dice model. It computes the expected win/lose outcome of each roll, compares it with the DUT's win/lose outputs, counts mismatches, and reports completion. It sits in the testbench layer beside the dice-game controller and replaces fixed-sequence game testers.

## Interface
- MAX_ROLLS, 16: table depth and maximum run length.
- SUM_W, 4: width of a sum (must hold 12).
- ERR_W, 8: mismatch counter width.
- CNT_W, $clog2(MAX_ROLLS+1): roll-count width.

- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start_i  in  1  one-cycle run request
- mode_i  in  1  0 = table replay, 1 = LFSR dice; sampled on accepted start
- seed_i  in  16  LFSR seed; sampled on accepted start
- n_rolls_i  in  CNT_W  rolls per run; sampled on accepted start
- tbl_we_i  in  1  table write enable
- tbl_addr_i  in  $clog2(MAX_ROLLS)  table write address
- tbl_data_i  in  SUM_W  table write data
- roll_i  in  1  DUT indicates it consumed the button press
- win_i, lose_i  in  1 each  DUT outcome
- rb_o  out  1  roll-button drive to DUT
- reset_o  out  1  new-game request to DUT
- sum_o  out  SUM_W  presented sum
- busy_o, done_o  out  1 each  run status
- roll_cnt_o  out  CNT_W  rolls completed
- err_cnt_o  out  ERR_W  saturating mismatch count

## Operation
- States: IDLE, WAIT_ROLL, PRESENT, CHECK, DONE.
- IDLE: accepts start_i. If the effective n_rolls is 0, go to DONE; otherwise go to WAIT_ROLL.
  - Effective n_rolls is n_rolls_i clamped to MAX_ROLLS.
  - On accept: clear roll_cnt and err_cnt, set first_roll = 1, load the LFSR.
- WAIT_ROLL: rb_o = 1. On roll_i = 1, register the next sum into sum_o, increment roll_cnt, go to PRESENT.
- PRESENT: one cycle, so the DUT sees the new sum.
- CHECK: sample win_i and lose_i.
  - reset_o = 1 combinationally if win_i || lose_i.
  - Mismatch when (win_i, lose_i) differs from (exp_win, exp_lose); err_cnt increments and saturates at all-ones.
  - Go to DONE if roll_cnt == n_rolls, else go to WAIT_ROLL.
- DONE: done_o = 1, held until rst or a new start_i.
  - A new start_i behaves as in IDLE; DONE is otherwise equivalent to IDLE.
- busy_o = 1 in WAIT_ROLL, PRESENT and CHECK. start_i is ignored while busy.
- Sum source, table mode: entry roll_cnt, zero-based.
- Sum source, LFSR mode:
  - 16-bit Fibonacci LFSR with taps 16,14,13,11, advanced once per roll.
  - d1 = (lfsr[2:0] mod 6) + 1 and d2 = (lfsr[5:3] mod 6) + 1, so each die is 1..6 and the mod-6 bias is accepted.
  - Sum = d1 + d2, range 2..12.
  - Seed 0 is replaced by 16'hACE1.
- Expected model, first roll: 7 or 11 → win; 2, 3 or 12 → lose; any other value becomes the stored point.
- Expected model, later rolls: sum == point → win; 7 → lose; otherwise no outcome.
- After any expected win or lose, first_roll returns to 1.
- Out-of-range table values are presented unchanged and treated as point values.
- Table writes are accepted in every state. A write to the entry currently being fetched is seen on the next read.

## Timing
- Reset values: rb_o 0, reset_o 0, sum_o 0, busy_o 0, done_o 0, roll_cnt_o 0, err_cnt_o 0; state IDLE; first_roll 1; point 0; LFSR 16'hACE1.
- rst asserted mid-run: all outputs take their reset values on the following edge. Table contents are retained.
- start_i → rb_o = 1 one cycle later.
- roll_i edge → sum_o valid the same edge; CHECK occurs 2 cycles after that edge.
- Minimum 3 cycles per roll.
- done_o rises on the edge that leaves the final CHECK.
- roll_i is ignored outside WAIT_ROLL.
- win_i and lose_i both 1: always counts as a mismatch, and reset_o = 1.

## Structure
- Shared package dice_pkg holds:
  - the state enum;
  - constants WIN_A = 7, WIN_B = 11, LOSE_A = 2, LOSE_B = 3, LOSE_C = 12;
  - the LFSR tap mask and DEFAULT_SEED = 16'hACE1.
- One sub-module, dice_lfsr: seed load, advance, and two-die sum output.
- Table, FSM and scoreboard are kept in the top module.

## Test plan
- Table 7,11,2,4,7,5,6,7,6,8,9,6 with n_rolls = 12 and a correct DUT model:
  - expected outcomes W,W,L,-,L,-,-,L,-,-,-,W;
  - reset_o pulses 6 times; err_cnt_o = 0; roll_cnt_o = 12; done_o = 1.
- Same table, DUT ties win_i = lose_i = 0 → err_cnt_o = 6. With ERR_W = 2 → err_cnt_o saturates at 3.
- LFSR mode, seed 0, n_rolls = 16 → every sum_o in 2..12; the run matches a bench model seeded with 16'hACE1.
- n_rolls_i = 0 → done_o = 1 one cycle after start_i; rb_o never asserts.
- n_rolls_i = 20 with MAX_ROLLS = 16 → the run stops at roll_cnt_o = 16.
- rst asserted during PRESENT of roll 5 → all outputs reset next cycle; table intact, so a re-run gives the same sums.
